// File: rtl/tpsram_arb_pkg.sv
// Shared types and sizes for the TPSRAM_C0 two-requester arbiter.
// Requester 0 is the restart/IAP flag logic, requester 1 the application datapath.
package tpsram_arb_pkg;

   localparam int AW   = 6;
   localparam int DW   = 8;
   localparam int NREQ = 2;

   typedef logic req_id_t;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
   } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Ties go to the requester that did not win last;
// `last` only moves when a grant is actually issued (en high).
module rr_arb2
   import tpsram_arb_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   output logic            any,
   output req_id_t         win,
   output logic [NREQ-1:0] gnt
);

   req_id_t last;

   // win is valid whenever any is high, independent of en, so the caller can
   // inspect the would-be winner before deciding to enable the grant.
   always_comb begin
      any = |req;
      win = (&req) ? ~last : req[1];
      gnt = '0;
      if (en && any) gnt[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         last <= 1'b1;
      else if (en && any) last <= win;
   end

endmodule

// File: rtl/tpsram_arbiter.sv
// Shares the 64x8 two-port SRAM between two requesters with independent write and
// read arbitration, same-address read deferral and per-requester read return.
module tpsram_arbiter
   import tpsram_arb_pkg::*;
#(
   parameter int RD_LAT = 1
)(
   input  logic          CLK,
   input  logic          RESETn,
   input  logic          i_rq0_req,
   input  logic          i_rq0_we,
   input  logic [AW-1:0] i_rq0_addr,
   input  logic [DW-1:0] i_rq0_wd,
   input  logic          i_rq1_req,
   input  logic          i_rq1_we,
   input  logic [AW-1:0] i_rq1_addr,
   input  logic [DW-1:0] i_rq1_wd,
   output logic          o_rq0_gnt,
   output logic          o_rq1_gnt,
   output logic          o_rq0_rvalid,
   output logic          o_rq1_rvalid,
   output logic [DW-1:0] o_rq0_rd,
   output logic [DW-1:0] o_rq1_rd,
   output logic [AW-1:0] o_TPSRAM_WADDR_sv,
   output logic [AW-1:0] o_TPSRAM_RADDR_sv,
   output logic [DW-1:0] o_TPSRAM_WD,
   output logic          o_TPSRAM_WEN,
   output logic          o_TPSRAM_REN,
   input  logic [DW-1:0] i_TPSRAM_RD_sv
);

   cmd_t [NREQ-1:0] cmd;
   logic [NREQ-1:0] req, wr_cand, rd_cand, wr_gnt, rd_gnt;
   logic            wr_any, rd_any, hazard;
   req_id_t         wr_win, rd_win;

   assign req    = {i_rq1_req, i_rq0_req};
   assign cmd[0] = '{we: i_rq0_we, addr: i_rq0_addr, wd: i_rq0_wd};
   assign cmd[1] = '{we: i_rq1_we, addr: i_rq1_addr, wd: i_rq1_wd};

   for (genvar n = 0; n < NREQ; n++) begin : g_cand
      assign wr_cand[n] = req[n] &  cmd[n].we;
      assign rd_cand[n] = req[n] & ~cmd[n].we;
   end

   rr_arb2 u_wr_arb (
      .clk(CLK), .rst_n(RESETn), .en(1'b1),
      .req(wr_cand), .any(wr_any), .win(wr_win), .gnt(wr_gnt)
   );

   // A same-address read is held back one cycle so it observes the write.
   assign hazard = wr_any & rd_any & (cmd[wr_win].addr == cmd[rd_win].addr);

   rr_arb2 u_rd_arb (
      .clk(CLK), .rst_n(RESETn), .en(~hazard),
      .req(rd_cand), .any(rd_any), .win(rd_win), .gnt(rd_gnt)
   );

   // Grants are forced low while reset is held so requesters never see a
   // command accepted that the issue registers will drop.
   assign o_rq0_gnt = RESETn & (wr_gnt[0] | rd_gnt[0]);
   assign o_rq1_gnt = RESETn & (wr_gnt[1] | rd_gnt[1]);

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         o_TPSRAM_WEN      <= 1'b0;
         o_TPSRAM_REN      <= 1'b0;
         o_TPSRAM_WADDR_sv <= '0;
         o_TPSRAM_RADDR_sv <= '0;
         o_TPSRAM_WD       <= '0;
      end else begin
         o_TPSRAM_WEN <= |wr_gnt;
         o_TPSRAM_REN <= |rd_gnt;
         if (|wr_gnt) begin
            o_TPSRAM_WADDR_sv <= cmd[wr_win].addr;
            o_TPSRAM_WD       <= cmd[wr_win].wd;
         end
         if (|rd_gnt) o_TPSRAM_RADDR_sv <= cmd[rd_win].addr;
      end
   end

   // Stage 0 lines up with REN; stage RD_LAT lines up with valid SRAM data.
   logic [RD_LAT:0] vld_pipe;
   logic [RD_LAT:0] id_pipe;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[RD_LAT-1:0], |rd_gnt};
         id_pipe  <= {id_pipe[RD_LAT-1:0], rd_win};
      end
   end

   assign o_rq0_rvalid = vld_pipe[RD_LAT] & ~id_pipe[RD_LAT];
   assign o_rq1_rvalid = vld_pipe[RD_LAT] &  id_pipe[RD_LAT];
   assign o_rq0_rd     = i_TPSRAM_RD_sv;
   assign o_rq1_rd     = i_TPSRAM_RD_sv;

endmodule

// File: tb/tb_tpsram_arbiter.sv
// Bench for tpsram_arbiter: directed scenarios on RD_LAT=1 and RD_LAT=2 instances
// plus randomized traffic against a rule-level grant/return model.
module tb_tpsram_arbiter;
   import tpsram_arb_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req, we;
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wd   [2];

   logic [1:0]    a_gnt, a_rv, b_gnt, b_rv;
   logic [DW-1:0] a_rd0, a_rd1, b_rd0, b_rd1, a_wd, b_wd, a_sram_rd, b_sram_rd;
   logic [AW-1:0] a_waddr, a_raddr, b_waddr, b_raddr;
   logic          a_wen, a_ren, b_wen, b_ren;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tpsram_arbiter #(.RD_LAT(1)) dut_a (
      .CLK(clk), .RESETn(rst_n),
      .i_rq0_req(req[0]), .i_rq0_we(we[0]), .i_rq0_addr(addr[0]), .i_rq0_wd(wd[0]),
      .i_rq1_req(req[1]), .i_rq1_we(we[1]), .i_rq1_addr(addr[1]), .i_rq1_wd(wd[1]),
      .o_rq0_gnt(a_gnt[0]), .o_rq1_gnt(a_gnt[1]), .o_rq0_rvalid(a_rv[0]), .o_rq1_rvalid(a_rv[1]),
      .o_rq0_rd(a_rd0), .o_rq1_rd(a_rd1),
      .o_TPSRAM_WADDR_sv(a_waddr), .o_TPSRAM_RADDR_sv(a_raddr), .o_TPSRAM_WD(a_wd),
      .o_TPSRAM_WEN(a_wen), .o_TPSRAM_REN(a_ren), .i_TPSRAM_RD_sv(a_sram_rd)
   );

   tpsram_arbiter #(.RD_LAT(2)) dut_b (
      .CLK(clk), .RESETn(rst_n),
      .i_rq0_req(req[0]), .i_rq0_we(we[0]), .i_rq0_addr(addr[0]), .i_rq0_wd(wd[0]),
      .i_rq1_req(req[1]), .i_rq1_we(we[1]), .i_rq1_addr(addr[1]), .i_rq1_wd(wd[1]),
      .o_rq0_gnt(b_gnt[0]), .o_rq1_gnt(b_gnt[1]), .o_rq0_rvalid(b_rv[0]), .o_rq1_rvalid(b_rv[1]),
      .o_rq0_rd(b_rd0), .o_rq1_rd(b_rd1),
      .o_TPSRAM_WADDR_sv(b_waddr), .o_TPSRAM_RADDR_sv(b_raddr), .o_TPSRAM_WD(b_wd),
      .o_TPSRAM_WEN(b_wen), .o_TPSRAM_REN(b_ren), .i_TPSRAM_RD_sv(b_sram_rd)
   );

   // SRAM models: one-cycle and two-cycle read latency
   logic [DW-1:0] mem_a [64];
   logic [DW-1:0] mem_b [64];
   logic [DW-1:0] b_stage;

   always @(posedge clk) begin
      if (a_wen) mem_a[a_waddr] <= a_wd;
      if (a_ren) a_sram_rd <= mem_a[a_raddr];
      if (b_wen) mem_b[b_waddr] <= b_wd;
      if (b_ren) b_stage <= mem_b[b_raddr];
      b_sram_rd <= b_stage;
   end

   task automatic set_rq(input int n, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[n] = r; we[n] = w; addr[n] = a; wd[n] = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      req = '0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_rq(0, 1'b1, 1'b1, 6'h01, 8'h11);
      set_rq(1, 1'b1, 1'b0, 6'h02, 8'h22);
      @(negedge clk);
      n_checks++; if (a_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", a_gnt); end
      n_checks++; if (b_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_b got=%b exp=00", b_gnt); end
      n_checks++; if ({a_wen, a_ren, a_rv} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes got=%b exp=0000", {a_wen, a_ren, a_rv}); end
      n_checks++; if ({a_waddr, a_raddr, a_wd} !== '0) begin n_fail++; $display("FAIL reset_addr got=%h/%h/%h exp=0", a_waddr, a_raddr, a_wd); end
      n_checks++; if ({b_wen, b_ren, b_rv} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes_b got=%b exp=0000", {b_wen, b_ren, b_rv}); end
      req = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single_rw();
      @(negedge clk);
      set_rq(0, 1'b1, 1'b1, 6'h03, 8'hA5);
      #1;
      n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL single_wgnt got=%b exp=01", a_gnt); end
      @(negedge clk);
      req = '0;
      n_checks++; if ({a_wen, a_waddr, a_wd} !== {1'b1, 6'h03, 8'hA5}) begin n_fail++; $display("FAIL single_wen got=%b/%h/%h exp=1/03/a5", a_wen, a_waddr, a_wd); end
      set_rq(0, 1'b1, 1'b0, 6'h03, 8'h00);
      #1;
      n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL single_rgnt got=%b exp=01", a_gnt); end
      @(negedge clk);
      req = '0;
      n_checks++; if ({a_ren, a_raddr, a_wen} !== {1'b1, 6'h03, 1'b0}) begin n_fail++; $display("FAIL single_ren got=%b/%h/%b exp=1/03/0", a_ren, a_raddr, a_wen); end
      n_checks++; if ({a_rv, b_rv} !== 4'b0) begin n_fail++; $display("FAIL single_rv_early got=%b/%b exp=00/00", a_rv, b_rv); end
      @(negedge clk);
      n_checks++; if (a_rv !== 2'b01 || a_rd0 !== 8'hA5) begin n_fail++; $display("FAIL single_rv got=%b/%h exp=01/a5", a_rv, a_rd0); end
      n_checks++; if (b_rv !== 2'b00) begin n_fail++; $display("FAIL lat2_early got=%b exp=00", b_rv); end
      @(negedge clk);
      n_checks++; if (b_rv !== 2'b01 || b_rd0 !== 8'hA5) begin n_fail++; $display("FAIL lat2_rv got=%b/%h exp=01/a5", b_rv, b_rd0); end
      n_checks++; if (a_rv !== 2'b00) begin n_fail++; $display("FAIL single_rv_once got=%b exp=00", a_rv); end
      @(negedge clk);
      n_checks++; if (b_rv !== 2'b00) begin n_fail++; $display("FAIL lat2_rv_once got=%b exp=00", b_rv); end
   endtask

   task automatic test_contention();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 1 && i <= 4) begin
            n_checks++;
            if (a_ren !== 1'b1 || a_raddr !== (((i - 1) % 2 == 0) ? 6'h10 : 6'h20)) begin
               n_fail++; $display("FAIL cont_ren[%0d] got=%b/%h", i, a_ren, a_raddr);
            end
         end
         if (i >= 2) begin
            n_checks++;
            if (a_rv !== (((i - 2) % 2 == 0) ? 2'b01 : 2'b10)) begin
               n_fail++; $display("FAIL cont_rv[%0d] got=%b exp=%b", i, a_rv, ((i - 2) % 2 == 0) ? 2'b01 : 2'b10);
            end
         end
         if (i < 4) begin
            set_rq(0, 1'b1, 1'b0, 6'h10, 8'h00);
            set_rq(1, 1'b1, 1'b0, 6'h20, 8'h00);
            #1;
            n_checks++;
            if (a_gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
               n_fail++; $display("FAIL cont_gnt[%0d] got=%b exp=%b", i, a_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
         end else begin
            req = '0;
         end
      end
   endtask

   task automatic test_concurrent();
      @(negedge clk);
      set_rq(0, 1'b1, 1'b1, 6'h05, 8'h11);
      set_rq(1, 1'b1, 1'b0, 6'h06, 8'h00);
      #1;
      n_checks++; if (a_gnt !== 2'b11) begin n_fail++; $display("FAIL conc_gnt got=%b exp=11", a_gnt); end
      @(negedge clk);
      req = '0;
      n_checks++;
      if ({a_wen, a_ren, a_waddr, a_raddr, a_wd} !== {1'b1, 1'b1, 6'h05, 6'h06, 8'h11}) begin
         n_fail++; $display("FAIL conc_issue got=%b%b/%h/%h/%h exp=11/05/06/11", a_wen, a_ren, a_waddr, a_raddr, a_wd);
      end
      @(negedge clk);
      n_checks++; if (a_rv !== 2'b10) begin n_fail++; $display("FAIL conc_rv got=%b exp=10", a_rv); end
   endtask

   task automatic test_hazard();
      @(negedge clk);
      set_rq(0, 1'b1, 1'b1, 6'h08, 8'h5A);
      set_rq(1, 1'b1, 1'b0, 6'h08, 8'h00);
      #1;
      n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL haz_gnt got=%b exp=01", a_gnt); end
      @(negedge clk);
      req[0] = 1'b0;
      n_checks++; if ({a_wen, a_ren} !== 2'b10) begin n_fail++; $display("FAIL haz_issue got=%b%b exp=10", a_wen, a_ren); end
      #1;
      n_checks++; if (a_gnt !== 2'b10) begin n_fail++; $display("FAIL haz_late_gnt got=%b exp=10", a_gnt); end
      @(negedge clk);
      req = '0;
      n_checks++; if (a_ren !== 1'b1 || a_raddr !== 6'h08) begin n_fail++; $display("FAIL haz_ren got=%b/%h exp=1/08", a_ren, a_raddr); end
      @(negedge clk);
      n_checks++; if (a_rv !== 2'b10 || a_rd1 !== 8'h5A) begin n_fail++; $display("FAIL haz_rd got=%b/%h exp=10/5a", a_rv, a_rd1); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      set_rq(0, 1'b1, 1'b0, 6'h03, 8'h00);
      #1;
      n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL rmid_gnt got=%b exp=01", a_gnt); end
      @(negedge clk);
      req = '0;
      n_checks++; if (a_ren !== 1'b1) begin n_fail++; $display("FAIL rmid_ren got=%b exp=1", a_ren); end
      #1;
      rst_n = 1'b0;
      set_rq(0, 1'b1, 1'b1, 6'h01, 8'h33);
      set_rq(1, 1'b1, 1'b1, 6'h02, 8'h44);
      #1;
      n_checks++;
      if ({a_gnt, a_rv, a_wen, a_ren, a_waddr, a_raddr, a_wd} !== '0) begin
         n_fail++; $display("FAIL rmid_outs got=%b/%b/%b%b/%h/%h/%h exp=0", a_gnt, a_rv, a_wen, a_ren, a_waddr, a_raddr, a_wd);
      end
      n_checks++; if ({b_gnt, b_rv, b_wen, b_ren} !== '0) begin n_fail++; $display("FAIL rmid_outs_b got=%b/%b/%b%b exp=0", b_gnt, b_rv, b_wen, b_ren); end
      @(negedge clk);
      req = '0;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++; if ({a_rv, b_rv} !== 4'b0) begin n_fail++; $display("FAIL rmid_norv[%0d] got=%b/%b exp=00/00", i, a_rv, b_rv); end
      end
      set_rq(0, 1'b1, 1'b1, 6'h01, 8'h33);
      set_rq(1, 1'b1, 1'b1, 6'h02, 8'h44);
      #1;
      n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL rmid_wtie got=%b exp=01", a_gnt); end
      @(negedge clk);
      set_rq(0, 1'b1, 1'b0, 6'h01, 8'h00);
      set_rq(1, 1'b1, 1'b0, 6'h02, 8'h00);
      #1;
      n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL rmid_rtie got=%b exp=01", a_gnt); end
      @(negedge clk);
      req = '0;
   endtask

   typedef struct {
      int due;
      int id;
      int data;
      bit known;
   } rexp_t;

   // Randomized traffic: the model applies the arbitration rules directly to the
   // pending commands and predicts grants, issue registers and read returns.
   task automatic test_random(input int ncyc);
      rexp_t q[$];
      bit    busy [2];
      bit    cw   [2];
      int    ca   [2];
      int    cd   [2];
      int    shadow [64];
      bit    known  [64];
      int    lw = 1, lr = 1;
      int    ew = 0, ewa = 0, ewd = 0, er = 0, era = 0;
      int    wid, rid;
      logic [1:0] eg, erv;
      rexp_t e;

      foreach (known[i]) known[i] = 1'b0;
      busy[0] = 1'b0; busy[1] = 1'b0;
      do_reset();
      for (int k = 0; k < ncyc + 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (a_wen !== 1'(ew) || a_waddr !== AW'(ewa) || a_wd !== DW'(ewd)) begin
            n_fail++; $display("FAIL rnd_wport[%0d] got=%b/%h/%h exp=%0d/%h/%h", k, a_wen, a_waddr, a_wd, ew, ewa, ewd);
         end
         n_checks++;
         if (a_ren !== 1'(er) || a_raddr !== AW'(era)) begin
            n_fail++; $display("FAIL rnd_rport[%0d] got=%b/%h exp=%0d/%h", k, a_ren, a_raddr, er, era);
         end
         erv = 2'b00;
         if (q.size() > 0 && q[0].due == k) begin
            e = q.pop_front();
            erv[e.id] = 1'b1;
            if (e.known) begin
               n_checks++;
               if ((e.id == 0 ? a_rd0 : a_rd1) !== DW'(e.data)) begin
                  n_fail++; $display("FAIL rnd_rd[%0d] id=%0d got=%h exp=%h", k, e.id, (e.id == 0 ? a_rd0 : a_rd1), e.data);
               end
            end
         end
         n_checks++; if (a_rv !== erv) begin n_fail++; $display("FAIL rnd_rv[%0d] got=%b exp=%b", k, a_rv, erv); end

         for (int n = 0; n < 2; n++) begin
            if (k >= ncyc) busy[n] = 1'b0;
            else if (busy[n] && $urandom_range(15) == 0) busy[n] = 1'b0;
            else if (!busy[n] && $urandom_range(2) != 0) begin
               busy[n] = 1'b1;
               cw[n]   = 1'($urandom_range(1));
               ca[n]   = $urandom_range(7);
               cd[n]   = $urandom_range(255);
            end
            set_rq(n, busy[n], cw[n], AW'(ca[n]), DW'(cd[n]));
         end
         #1;
         wid = -1; rid = -1;
         if (busy[0] && cw[0] && busy[1] && cw[1]) wid = 1 - lw;
         else if (busy[0] && cw[0]) wid = 0;
         else if (busy[1] && cw[1]) wid = 1;
         if (busy[0] && !cw[0] && busy[1] && !cw[1]) rid = 1 - lr;
         else if (busy[0] && !cw[0]) rid = 0;
         else if (busy[1] && !cw[1]) rid = 1;
         if (wid >= 0 && rid >= 0 && ca[wid] == ca[rid]) rid = -1;
         eg = 2'b00;
         if (wid >= 0) eg[wid] = 1'b1;
         if (rid >= 0) eg[rid] = 1'b1;
         n_checks++; if (a_gnt !== eg) begin n_fail++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", k, a_gnt, eg); end

         ew = (wid >= 0) ? 1 : 0;
         if (wid >= 0) begin
            lw = wid; ewa = ca[wid]; ewd = cd[wid];
            shadow[ca[wid]] = cd[wid]; known[ca[wid]] = 1'b1;
            busy[wid] = 1'b0;
         end
         er = (rid >= 0) ? 1 : 0;
         if (rid >= 0) begin
            lr = rid; era = ca[rid];
            q.push_back('{due: k + 2, id: rid, data: shadow[ca[rid]], known: known[ca[rid]]});
            busy[rid] = 1'b0;
         end
      end
      req = '0;
      n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got=%0d exp=0 pending", q.size()); end
   endtask

   initial begin
      foreach (mem_a[i]) begin mem_a[i] = '0; mem_b[i] = '0; end
      req = '0; we = '0;
      addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
      test_reset();
      test_single_rw();
      test_contention();
      test_concurrent();
      test_hazard();
      test_reset_mid();
      test_random(400);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
